// File: rtl/pga_gain_sequencer_if.sv
// Bundles the gain-request, status and PGA SPI pin signals of the gain sequencer.
// Signal suffixes are taken from the sequencer's point of view.
interface pga_gain_sequencer_if;
    logic [7:0] gain_dB_i;
    logic       set_gain_i;
    logic       pga_sclk_o;
    logic       pga_mosi_o;
    logic       pga_cs_n_o;
    logic       blank_o;
    logic       busy_o;
    logic [7:0] gain_applied_o;
    logic       done_o;

    modport master (
        output gain_dB_i, set_gain_i,
        input  pga_sclk_o, pga_mosi_o, pga_cs_n_o, blank_o, busy_o, gain_applied_o, done_o
    );

    modport slave (
        input  gain_dB_i, set_gain_i,
        output pga_sclk_o, pga_mosi_o, pga_cs_n_o, blank_o, busy_o, gain_applied_o, done_o
    );
endinterface

// File: rtl/pga_gain_sequencer.sv
// Clamps gain requests, writes them to the PGA as 16-bit SPI frames (mode 0, MSB first)
// and blanks the sample pipeline for a fixed settle time after every write.
module pga_gain_sequencer #(
    parameter int         CLK_DIV       = 4,
    parameter int         SETTLE_CYCLES = 1000,
    parameter int         MIN_GAIN_DB   = -8,
    parameter int         MAX_GAIN_DB   = 40,
    parameter int         INIT_GAIN_DB  = 0,
    parameter logic [7:0] CMD_BYTE      = 8'h2A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pga_gain_sequencer_if.slave  bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam int INIT_CLAMP = (INIT_GAIN_DB < MIN_GAIN_DB) ? MIN_GAIN_DB :
                                (INIT_GAIN_DB > MAX_GAIN_DB) ? MAX_GAIN_DB : INIT_GAIN_DB;
    localparam logic [7:0] INIT_REQ     = 8'(INIT_CLAMP);
    localparam logic [7:0] INIT_APPLIED = 8'(INIT_GAIN_DB);
    localparam logic [7:0] MIN_CODE_OFS = 8'(MIN_GAIN_DB);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SETTLE} state_t;

    function automatic logic [7:0] clamp_gain(input logic [7:0] g);
        int v;
        v = int'($signed(g));
        if (v < MIN_GAIN_DB)      v = MIN_GAIN_DB;
        else if (v > MAX_GAIN_DB) v = MAX_GAIN_DB;
        return v[7:0];
    endfunction

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic [7:0]       req_q, req_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       applied_q, applied_d;
    logic [15:0]      frame_q, frame_d;
    logic [3:0]       bit_q, bit_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic             cs_n_q, sclk_q, mosi_q;
    logic             cs_n_d, sclk_d, mosi_d;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        req_d     = req_q;
        cur_d     = cur_q;
        applied_d = applied_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        div_d     = div_q;
        phase_d   = phase_q;
        settle_d  = settle_q;

        if (bus.set_gain_i) begin
            req_d = clamp_gain(bus.gain_dB_i);
        end

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    if (req_q == applied_q) pending_d = 1'b0;
                    else                    state_d   = LOAD;
                end
            end
            LOAD: begin
                frame_d   = {CMD_BYTE, req_q - MIN_CODE_OFS};
                pending_d = 1'b0;
                cur_d     = req_q;
                bit_d     = 4'd15;
                div_d     = '0;
                phase_d   = 1'b0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d   = SETTLE;
                            settle_d  = '0;
                            applied_d = cur_q;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            frame_d = {frame_q[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == SET_LAST) state_d  = IDLE;
                else                      settle_d = settle_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A strobe always leaves a request pending, even when LOAD consumes one this cycle.
        if (bus.set_gain_i) begin
            pending_d = 1'b1;
        end

        // Pins are registered from next-state values so they never glitch.
        cs_n_d = (state_d != SHIFT);
        sclk_d = (state_d == SHIFT) && phase_d;
        mosi_d = (state_d == SHIFT) && frame_d[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            pending_q <= 1'b1;
            req_q     <= INIT_REQ;
            cur_q     <= INIT_REQ;
            applied_q <= INIT_APPLIED;
            frame_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            settle_q  <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            cur_q     <= cur_d;
            applied_q <= applied_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            settle_q  <= settle_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign bus.pga_cs_n_o     = cs_n_q;
    assign bus.pga_sclk_o     = sclk_q;
    assign bus.pga_mosi_o     = mosi_q;
    assign bus.busy_o         = (state_q != IDLE);
    assign bus.blank_o        = (state_q != IDLE);
    assign bus.done_o         = (state_q == SETTLE) && (settle_q == SET_LAST);
    assign bus.gain_applied_o = applied_q;

endmodule

// File: tb/tb_pga_gain_sequencer.sv
// Directed bench for pga_gain_sequencer: an SPI monitor reassembles frames and timing,
// the main flow drives requests and compares against hand-computed frames and gains.
module tb_pga_gain_sequencer;

    localparam int CLK_DIV = 2;
    localparam int SETTLE  = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pga_gain_sequencer_if bus ();

    pga_gain_sequencer #(
        .CLK_DIV       (CLK_DIV),
        .SETTLE_CYCLES (SETTLE),
        .MIN_GAIN_DB   (-8),
        .MAX_GAIN_DB   (40),
        .INIT_GAIN_DB  (0),
        .CMD_BYTE      (8'h2A)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor state, updated on every falling clk edge.
    logic [15:0] frames_q[$];
    logic [15:0] shreg       = '0;
    logic        prev_cs     = 1'b1;
    logic        prev_sclk   = 1'b0;
    logic        mosi_hi     = 1'b0;
    logic [7:0]  ga_at_rise  = '0;
    int          bits        = 0;
    int          low_ctr     = 0;
    int          last_low    = 0;
    int          last_bits   = 0;
    int          settle_ctr  = 0;
    int          last_settle = 0;
    int          done_cnt    = 0;
    int          stable_err  = 0;
    int          busy_seen   = 0;

    always @(negedge clk) begin
        if (prev_cs && !bus.pga_cs_n_o) begin
            low_ctr = 0;
            bits    = 0;
            shreg   = '0;
        end
        if (!bus.pga_cs_n_o) low_ctr++;
        if (!prev_sclk && bus.pga_sclk_o) begin
            shreg   = {shreg[14:0], bus.pga_mosi_o};
            bits++;
            mosi_hi = bus.pga_mosi_o;
        end else if (prev_sclk && bus.pga_sclk_o && (bus.pga_mosi_o != mosi_hi)) begin
            stable_err++;
        end
        if (!prev_cs && bus.pga_cs_n_o) begin
            frames_q.push_back(shreg);
            last_low   = low_ctr;
            last_bits  = bits;
            ga_at_rise = bus.gain_applied_o;
            settle_ctr = 0;
        end
        settle_ctr++;
        if (bus.done_o) begin
            done_cnt++;
            last_settle = settle_ctr;
        end
        if (bus.busy_o) busy_seen++;
        prev_cs   = bus.pga_cs_n_o;
        prev_sclk = bus.pga_sclk_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        frames_q.delete();
        done_cnt   = 0;
        busy_seen  = 0;
        stable_err = 0;
    endtask

    task automatic strobe(input logic [7:0] g);
        bus.gain_dB_i  = g;
        bus.set_gain_i = 1'b1;
        tick();
        bus.set_gain_i = 1'b0;
        $display("[TB] strobe gain_dB_i=%0d", $signed(g));
    endtask

    // Waits until busy_o has been low for 4 consecutive cycles, so a single
    // IDLE cycle between back-to-back writes does not end the wait.
    task automatic run_until_idle(input string tag);
        int idle_run;
        idle_run = 0;
        repeat (3) tick();
        for (int i = 0; i < 2000 && idle_run < 4; i++) begin
            tick();
            if (!bus.busy_o) idle_run++;
            else             idle_run = 0;
        end
        if (idle_run < 4) check({tag, "_idle_timeout"}, 32'(idle_run), 32'd4);
    endtask

    task automatic wait_cs_low(input string tag);
        int n;
        n = 0;
        while (bus.pga_cs_n_o && n < 200) begin
            tick();
            n++;
        end
        if (bus.pga_cs_n_o) check({tag, "_cs_timeout"}, 32'(bus.pga_cs_n_o), 32'd0);
    endtask

    task automatic expect_one_frame(input string tag, input logic [15:0] frame, input logic [7:0] ga);
        check({tag, "_nframes"}, 32'(frames_q.size()), 32'd1);
        check({tag, "_frame"}, 32'(frames_q.size() > 0 ? frames_q[0] : 16'h0), 32'(frame));
        check({tag, "_ga_at_cs_rise"}, 32'(ga_at_rise), 32'(ga));
        check({tag, "_gain_applied"}, 32'(bus.gain_applied_o), 32'(ga));
        check({tag, "_done"}, 32'(done_cnt), 32'd1);
        check({tag, "_mosi_stable"}, 32'(stable_err), 32'd0);
        $display("[TB] %s frame=0x%04h gain_applied=%0d", tag,
                 frames_q.size() > 0 ? frames_q[0] : 16'h0, $signed(bus.gain_applied_o));
    endtask

    initial begin
        bus.gain_dB_i  = '0;
        bus.set_gain_i = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_cs_n", 32'(bus.pga_cs_n_o), 32'd1);
        check("rst_sclk", 32'(bus.pga_sclk_o), 32'd0);
        check("rst_mosi", 32'(bus.pga_mosi_o), 32'd0);
        check("rst_blank", 32'(bus.blank_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd1);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_gain_applied", 32'(bus.gain_applied_o), 32'd0);
        $display("[TB] reset state sampled");

        // 1. init write after reset release
        clear_mon();
        rst_n = 1'b1;
        run_until_idle("init");
        expect_one_frame("init", 16'h2A08, 8'd0);
        check("init_shift_cycles", 32'(last_low), 32'(32 * CLK_DIV));
        check("init_bits", 32'(last_bits), 32'd16);
        check("init_settle_cycles", 32'(last_settle), 32'(SETTLE));
        check("init_blank_idle", 32'(bus.blank_o), 32'd0);

        // 2. in-range request
        clear_mon();
        strobe(8'd20);
        run_until_idle("g20");
        expect_one_frame("g20", 16'h2A1C, 8'd20);
        check("g20_shift_cycles", 32'(last_low), 32'(32 * CLK_DIV));

        // 3. out-of-range requests saturate
        clear_mon();
        strobe(8'd100);
        run_until_idle("g100");
        expect_one_frame("g100", 16'h2A30, 8'd40);
        clear_mon();
        strobe(8'hCE);
        run_until_idle("gm50");
        expect_one_frame("gm50", 16'h2A00, 8'hF8);

        // 4. strobes during SHIFT coalesce into one further frame
        clear_mon();
        strobe(8'd30);
        wait_cs_low("coal");
        strobe(8'd10);
        strobe(8'd12);
        strobe(8'd14);
        run_until_idle("coal");
        check("coal_nframes", 32'(frames_q.size()), 32'd2);
        check("coal_frame0", 32'(frames_q.size() > 0 ? frames_q[0] : 16'h0), 32'h2A26);
        check("coal_frame1", 32'(frames_q.size() > 1 ? frames_q[1] : 16'h0), 32'h2A16);
        check("coal_done", 32'(done_cnt), 32'd2);
        check("coal_gain_applied", 32'(bus.gain_applied_o), 32'd14);
        $display("[TB] coalesce frames=%0d done=%0d", frames_q.size(), done_cnt);

        // 5. request equal to applied gain is a no-op
        clear_mon();
        strobe(8'd14);
        repeat (20) tick();
        check("same_nframes", 32'(frames_q.size()), 32'd0);
        check("same_busy", 32'(busy_seen), 32'd0);
        check("same_done", 32'(done_cnt), 32'd0);
        $display("[TB] equal request busy_cycles=%0d", busy_seen);

        // 6. reset during bit 7 aborts the frame, init frame resent
        clear_mon();
        strobe(8'd20);
        wait_cs_low("rstmid");
        for (int i = 0; i < 200 && !(bits == 9 && bus.pga_sclk_o); i++) tick();
        check("rstmid_reached_bit7", 32'(bits), 32'd9);
        rst_n = 1'b0;
        #1;
        check("rstmid_cs_n", 32'(bus.pga_cs_n_o), 32'd1);
        check("rstmid_sclk", 32'(bus.pga_sclk_o), 32'd0);
        check("rstmid_gain_applied", 32'(bus.gain_applied_o), 32'd0);
        repeat (3) tick();
        clear_mon();
        rst_n = 1'b1;
        run_until_idle("rstmid");
        expect_one_frame("rstmid", 16'h2A08, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
